// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - MIPS data memory, byte/half/word big-endian access, REQ/READY/VALID, optional DMEM_MISALIGN_TRAP_EN
module data_memory_sized #(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              REQ,
    input  logic              W_EN,
    input  logic [1:0]        SIZE,
    input  logic              SIGN_EXT,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       D_IN,
    output logic              READY,
    output logic              VALID,
    output logic [31:0]       D_OUT,
    output logic              ERR
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PIPE = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-3:0] widx;
    logic              accept;
    logic              mem_we;

    // Normalised request attributes (size 11 behaves as word)
    logic [1:0] a_sz;
    logic [1:0] a_off;
    logic       a_err;

    // Second register stage, used only when RD_LATENCY == 2
    logic        p_load;
    logic        p_err;
    logic [1:0]  p_sz;
    logic        p_sign;
    logic [1:0]  p_off;
    logic [31:0] p_word;

    // Operation feeding the output register in the cycle before VALID
    logic        o_load;
    logic        o_err;
    logic [1:0]  o_sz;
    logic        o_sign;
    logic [1:0]  o_off;
    logic [31:0] o_word;

    // Merge right-justified store data into the addressed big-endian lanes
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] din,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = old;
        case (sz)
            2'b00: begin
                case (off)
                    2'd0:    r[31:24] = din[7:0];
                    2'd1:    r[23:16] = din[7:0];
                    2'd2:    r[15:8]  = din[7:0];
                    default: r[7:0]   = din[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) r[15:0]  = din[15:0];
                else        r[31:16] = din[15:0];
            end
            default: r = din;
        endcase
        return r;
    endfunction

    // Pick the addressed lane and extend it to 32 bits
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  off,
                                                 input logic        sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign widx   = ADDR[ADDR_W-1:2];
    assign READY  = (state != PIPE);
    assign VALID  = (state == RESP);
    assign accept = REQ && READY;
    assign a_sz   = (SIZE == 2'b11) ? 2'b10 : SIZE;

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misaligned half/word accesses are trapped and leave the array untouched
    always_comb begin
        a_off = ADDR[1:0];
        a_err = ((a_sz == 2'b01) && ADDR[0]) ||
                ((a_sz == 2'b10) && (ADDR[1:0] != 2'b00));
    end
`else
    // Low address bits below the access size are ignored
    always_comb begin
        a_err = 1'b0;
        case (a_sz)
            2'b00:   a_off = ADDR[1:0];
            2'b01:   a_off = {ADDR[1], 1'b0};
            default: a_off = 2'b00;
        endcase
    end
`endif

    // Stores commit on the accept edge; held off while reset is asserted
    assign mem_we = accept && W_EN && !a_err && rst_n;

    // Array write port; the array is deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[widx] <= store_merge(mem[widx], D_IN, a_sz, a_off);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: PIPE is inserted only for two-cycle read latency
    always_comb begin
        state_nxt = IDLE;
        case (state)
            PIPE:    state_nxt = RESP;
            default: begin
                if (accept) state_nxt = (RD_LATENCY == 2) ? PIPE : RESP;
                else        state_nxt = IDLE;
            end
        endcase
    end

    // Capture the accepted operation and its array word for the second stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_load <= 1'b0;
            p_err  <= 1'b0;
            p_sz   <= 2'b00;
            p_sign <= 1'b0;
            p_off  <= 2'b00;
            p_word <= 32'h0;
        end else if (accept) begin
            p_load <= ~W_EN;
            p_err  <= a_err;
            p_sz   <= a_sz;
            p_sign <= SIGN_EXT;
            p_off  <= a_off;
            p_word <= mem[widx];
        end
    end

    // Select the operation that completes on the edge entering RESP
    always_comb begin
        if (RD_LATENCY == 2) begin
            o_load = p_load;
            o_err  = p_err;
            o_sz   = p_sz;
            o_sign = p_sign;
            o_off  = p_off;
            o_word = p_word;
        end else begin
            o_load = ~W_EN;
            o_err  = a_err;
            o_sz   = a_sz;
            o_sign = SIGN_EXT;
            o_off  = a_off;
            o_word = mem[widx];
        end
    end

    // Response registers: D_OUT changes only when a good load completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_OUT <= 32'h0;
            ERR   <= 1'b0;
        end else begin
            ERR <= (state_nxt == RESP) && o_err;
            if ((state_nxt == RESP) && o_load && !o_err) begin
                D_OUT <= load_extract(o_word, o_sz, o_off, o_sign);
            end
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - scoreboard bench for data_memory_sized at read latency 1 and 2
module tb_data_memory_sized;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req1 = 1'b0;
    logic        req2 = 1'b0;
    logic        w_en = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [9:0]  addr = 10'h0;
    logic [31:0] d_in = 32'h0;
    logic        ready1, valid1, err1;
    logic        ready2, valid2, err2;
    logic [31:0] dout1, dout2;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] last_d [2];
    bit          trap;

    data_memory_sized #(.ADDR_W(10), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .REQ(req1), .W_EN(w_en), .SIZE(size),
        .SIGN_EXT(sign_ext), .ADDR(addr), .D_IN(d_in),
        .READY(ready1), .VALID(valid1), .D_OUT(dout1), .ERR(err1));

    data_memory_sized #(.ADDR_W(10), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .REQ(req2), .W_EN(w_en), .SIZE(size),
        .SIGN_EXT(sign_ext), .ADDR(addr), .D_IN(d_in),
        .READY(ready2), .VALID(valid2), .D_OUT(dout2), .ERR(err2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request; returns #1 after its accept edge so the next call is back-to-back
    task automatic issue(input bit d2, input bit we, input logic [1:0] sz, input bit sx,
                         input logic [9:0] a, input logic [31:0] din,
                         input logic [31:0] exp_d, input bit exp_err, input bit resp);
        int   n;
        exp_t e;
        n = 0;
        w_en = we; size = sz; sign_ext = sx; addr = a; d_in = din;
        if (d2) req2 = 1'b1; else req1 = 1'b1;
        while (!(d2 ? ready2 : ready1)) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                chk("ready_timeout", 32'(n), 32'd0);
                req1 = 1'b0; req2 = 1'b0;
                return;
            end
        end
        e.cyc = cyc + (d2 ? 2 : 1);
        e.err = exp_err;
        if (!we && !exp_err) last_d[d2] = exp_d;
        e.d = last_d[d2];
        if (resp) begin
            if (d2) q2.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        #1;
        req1 = 1'b0; req2 = 1'b0;
    endtask

    // Monitor for the latency-1 instance
    always @(negedge clk) begin
        if (rst_n && valid1) begin
            if (q1.size() == 0) chk("dut1_unexpected_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_valid_cycle", 32'(cyc), 32'(e.cyc));
                chk("dut1_d_out", dout1, e.d);
                chk("dut1_err", 32'(err1), 32'(e.err));
            end
        end else if (rst_n && err1) chk("dut1_err_without_valid", 32'd1, 32'd0);
    end

    // Monitor for the latency-2 instance
    always @(negedge clk) begin
        if (rst_n && valid2) begin
            if (q2.size() == 0) chk("dut2_unexpected_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q2.pop_front();
                chk("dut2_valid_cycle", 32'(cyc), 32'(e.cyc));
                chk("dut2_d_out", dout2, e.d);
                chk("dut2_err", 32'(err2), 32'(e.err));
            end
        end else if (rst_n && err2) chk("dut2_err_without_valid", 32'd1, 32'd0);
    end

    initial begin
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        last_d[0] = 32'h0;
        last_d[1] = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready1", 32'(ready1), 32'd1);
        chk("rst_valid1", 32'(valid1), 32'd0);
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_err1", 32'(err1), 32'd0);
        chk("rst_ready2", 32'(ready2), 32'd1);
        chk("rst_dout2", dout2, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word store and load
        issue(0, 1, 2'b10, 0, 10'h010, 32'h8899AABB, 32'h0, 0, 1);
        issue(0, 0, 2'b10, 0, 10'h010, 32'h0, 32'h8899AABB, 0, 1);
        // Byte store into lane 1, then byte loads and word readback
        issue(0, 1, 2'b00, 0, 10'h011, 32'h0000007F, 32'h0, 0, 1);
        issue(0, 0, 2'b00, 1, 10'h010, 32'h0, 32'hFFFFFF88, 0, 1);
        issue(0, 0, 2'b00, 0, 10'h011, 32'h0, 32'h0000007F, 0, 1);
        issue(0, 0, 2'b10, 0, 10'h010, 32'h0, 32'h887FAABB, 0, 1);
        // Half accesses
        issue(0, 1, 2'b10, 0, 10'h020, 32'h0, 32'h0, 0, 1);
        issue(0, 1, 2'b01, 0, 10'h022, 32'h0000C001, 32'h0, 0, 1);
        issue(0, 0, 2'b01, 1, 10'h022, 32'h0, 32'hFFFFC001, 0, 1);
        issue(0, 0, 2'b01, 0, 10'h020, 32'h0, 32'h00000000, 0, 1);
        issue(0, 0, 2'b01, 1, 10'h010, 32'h0, 32'hFFFF887F, 0, 1);
        // Reserved size reads as a word
        issue(0, 0, 2'b11, 0, 10'h010, 32'h0, 32'h887FAABB, 0, 1);
        @(negedge clk);

        // Misaligned word store
        issue(0, 1, 2'b10, 0, 10'h013, 32'h12345678, 32'h0, trap, 1);
        issue(0, 0, 2'b10, 0, 10'h010, 32'h0, trap ? 32'h887FAABB : 32'h12345678, 0, 1);
        // Misaligned half load
        issue(0, 0, 2'b01, 1, 10'h011, 32'h0, trap ? 32'h0 : 32'h00001234, trap, 1);
        @(negedge clk);

        // Latency 2: READY drops for one cycle, back-to-back accept in the VALID cycle
        issue(1, 1, 2'b10, 0, 10'h040, 32'hCAFEF00D, 32'h0, 0, 1);
        chk("dut2_ready_low_after_store", 32'(ready2), 32'd0);
        issue(1, 0, 2'b10, 0, 10'h040, 32'h0, 32'hCAFEF00D, 0, 1);
        chk("dut2_ready_low_after_load", 32'(ready2), 32'd0);
        issue(1, 0, 2'b00, 0, 10'h041, 32'h0, 32'h000000FE, 0, 1);
        issue(1, 0, 2'b01, 1, 10'h042, 32'h0, 32'hFFFFF00D, 0, 1);
        repeat (3) @(negedge clk);

        // Reset while a latency-2 load is in flight
        issue(1, 0, 2'b10, 0, 10'h010, 32'h0, 32'h0, 0, 0);
        rst_n = 1'b0;
        last_d[0] = 32'h0;
        last_d[1] = 32'h0;
        @(posedge clk);
        #1;
        chk("inflight_rst_valid", 32'(valid2), 32'd0);
        chk("inflight_rst_dout", dout2, 32'h0);
        chk("inflight_rst_ready", 32'(ready2), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_dout1", dout1, 32'h0);
        issue(1, 0, 2'b10, 0, 10'h040, 32'h0, 32'hCAFEF00D, 0, 1);
        issue(0, 0, 2'b10, 0, 10'h010, 32'h0, trap ? 32'h887FAABB : 32'h12345678, 0, 1);

        for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        chk("pending_responses", 32'(q1.size() + q2.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
